// File: rtl/ova_pkg.sv
// Shared types and the accumulate primitive for the overlap-add stage.
// Build option OVA_SATURATE_EN: accumulation clamps at all-ones instead of wrapping.
package ova_pkg;

  localparam int DATA_W = 32;

  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic data_t add(input data_t a, input data_t b);
    logic [DATA_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
`ifdef OVA_SATURATE_EN
    add = sum[DATA_W] ? {DATA_W{1'b1}} : sum[DATA_W-1:0];
`else
    add = sum[DATA_W-1:0];
`endif
  endfunction

endpackage

// File: rtl/overlap_add_if.sv
// Tile/plane bundle between the overlap-add stage and its producer/consumer.
// Build option OVA_SATURATE_EN has no effect on this file.
interface overlap_add_if #(
  parameter int num_block_root = 4,
  parameter int size           = 5,
  parameter int overlap        = size - 1
);
  import ova_pkg::*;

  localparam int N          = num_block_root * num_block_root;
  localparam int outputsize = num_block_root * size - (num_block_root - 1) * overlap;

  logic  control;
  data_t blocks_in    [N][size][size];
  data_t overlap_data [outputsize][outputsize];
  logic  done;

  modport master (output control, blocks_in, input overlap_data, done);
  modport slave  (input control, blocks_in, output overlap_data, done);

endinterface

// File: rtl/ova_tile_window.sv
// Maps tile k onto its output window: each plane cell gets the overlapping tile element or 0.
// Build option OVA_SATURATE_EN has no effect on this file.
module ova_tile_window
  import ova_pkg::*;
#(
  parameter  int num_block_root = 4,
  parameter  int size           = 5,
  parameter  int overlap        = size - 1,
  localparam int N              = num_block_root * num_block_root,
  localparam int KW             = (N > 1) ? $clog2(N) : 1,
  localparam int outputsize     = num_block_root * size - (num_block_root - 1) * overlap
) (
  input  logic [KW-1:0] k,
  input  data_t         blocks_in [N][size][size],
  output data_t         add_val   [outputsize][outputsize]
);

  localparam int STRIDE = size - overlap;

  int gr_off;
  int gc_off;

  always_comb begin
    gr_off = (int'(k) / num_block_root) * STRIDE;
    gc_off = (int'(k) % num_block_root) * STRIDE;
  end

  always_comb begin
    for (int i = 0; i < outputsize; i++) begin
      for (int j = 0; j < outputsize; j++) begin
        add_val[i][j] = '0;
        if (i >= gr_off && i < gr_off + size && j >= gc_off && j < gc_off + size)
          add_val[i][j] = blocks_in[k][i - gr_off][j - gc_off];
      end
    end
  end

endmodule

// File: rtl/overlap_add.sv
// Overlap-add reassembly: sums a grid of square tiles, one per clock, into a held output plane.
// Build option OVA_SATURATE_EN: saturating accumulation (default wraps modulo 2^32).
//
//   state | meaning
//   IDLE  | waiting for control; plane holds last result
//   ACCUM | adding tile k into its window each clock
//   DONE  | result held, done high until control drops
module overlap_add
  import ova_pkg::*;
#(
  parameter int num_block_root = 4,
  parameter int size           = 5,
  parameter int overlap        = size - 1
) (
  input logic          clk,
  input logic          reset,
  overlap_add_if.slave bus
);

  localparam int N          = num_block_root * num_block_root;
  localparam int KW         = (N > 1) ? $clog2(N) : 1;
  localparam int outputsize = num_block_root * size - (num_block_root - 1) * overlap;

  state_t        state;
  state_t        state_nxt;
  logic [KW-1:0] k;
  logic          done_q;
  logic          clr;
  logic          acc;
  data_t         plane   [outputsize][outputsize];
  data_t         add_val [outputsize][outputsize];

  ova_tile_window #(
    .num_block_root(num_block_root),
    .size          (size),
    .overlap       (overlap)
  ) u_window (
    .k        (k),
    .blocks_in(bus.blocks_in),
    .add_val  (add_val)
  );

  always_comb begin
    state_nxt = state;
    clr       = 1'b0;
    acc       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.control) begin
          clr       = 1'b1;
          state_nxt = ACCUM;
        end
      end
      ACCUM: begin
        acc = 1'b1;
        if (k == KW'(N - 1))
          state_nxt = DONE;
      end
      DONE: begin
        if (!bus.control)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      k      <= '0;
      done_q <= 1'b0;
      for (int i = 0; i < outputsize; i++)
        for (int j = 0; j < outputsize; j++)
          plane[i][j] <= '0;
    end else begin
      state  <= state_nxt;
      done_q <= (state_nxt == DONE);
      if (clr)
        k <= '0;
      else if (acc)
        k <= k + KW'(1);
      for (int i = 0; i < outputsize; i++) begin
        for (int j = 0; j < outputsize; j++) begin
          if (clr)
            plane[i][j] <= '0;
          else if (acc)
            plane[i][j] <= add(plane[i][j], add_val[i][j]);
        end
      end
    end
  end

  assign bus.overlap_data = plane;
  assign bus.done         = done_q;

endmodule

// File: tb/tb_overlap_add.sv
// Scoreboard bench for overlap_add: default 4x4 grid of 5x5 tiles plus a 2x2 grid of 3x3 tiles.
// Expected results for the OVA_SATURATE_EN build are selected by the same macro.
module tb_overlap_add;
  import ova_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  overlap_add_if #(.num_block_root(4), .size(5), .overlap(4)) bus_a ();
  overlap_add_if #(.num_block_root(2), .size(3), .overlap(1)) bus_b ();

  overlap_add #(.num_block_root(4), .size(5), .overlap(4)) dut_a (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_a)
  );

  overlap_add #(.num_block_root(2), .size(3), .overlap(1)) dut_b (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_b)
  );

  // kind: 0 = plane cell, 1 = done flag, 2 = edges since start
  typedef struct {
    int    dut;
    int    kind;
    int    r;
    int    c;
    data_t val;
    string name;
  } exp_t;

  exp_t q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  int   start_cyc   = 0;
  int   snap_cnt    = 0;
  int   snap_seen   = 0;
  logic a_prev      = 1'b0;
  logic b_prev      = 1'b0;

  int w_tab[8] = '{1, 2, 3, 4, 4, 3, 2, 1};

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: drains the scoreboard when either DUT raises done or a snapshot is requested.
  exp_t  m_e;
  data_t m_act;
  logic  m_trig;
  always @(negedge clk) begin
    m_trig = (snap_cnt != snap_seen) || (bus_a.done && !a_prev) || (bus_b.done && !b_prev);
    a_prev = bus_a.done;
    b_prev = bus_b.done;
    snap_seen = snap_cnt;
    if (m_trig) begin
      while (q.size() > 0) begin
        m_e = q.pop_front();
        if (m_e.kind == 1)
          m_act = (m_e.dut == 0) ? data_t'(bus_a.done) : data_t'(bus_b.done);
        else if (m_e.kind == 2)
          m_act = data_t'(cyc - start_cyc);
        else if (m_e.dut == 0)
          m_act = bus_a.overlap_data[m_e.r][m_e.c];
        else
          m_act = bus_b.overlap_data[m_e.r][m_e.c];
        vectors++;
        if (m_act !== m_e.val) begin
          miscompares++;
          $display("FAIL %s dut%0d [%0d][%0d]: got %h, expected %h",
                   m_e.name, m_e.dut, m_e.r, m_e.c, m_act, m_e.val);
        end
      end
    end
  end

  task automatic push(input int dut, input int kind, input int r, input int c,
                      input data_t val, input string name);
    exp_t e;
    e.dut  = dut;
    e.kind = kind;
    e.r    = r;
    e.c    = c;
    e.val  = val;
    e.name = name;
    q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int budget, input string what);
    for (int i = 0; i < budget && q.size() > 0; i++) @(posedge clk);
    #1;
    if (q.size() > 0) begin
      $display("FAIL timeout %s: %0d checks pending, expected 0", what, q.size());
      snap_cnt++;
      step(1);
    end
  endtask

  task automatic snap(input string what);
    snap_cnt++;
    wait_drain(4, what);
  endtask

  task automatic fill_a_const(input data_t v);
    for (int b = 0; b < 16; b++)
      for (int r = 0; r < 5; r++)
        for (int c = 0; c < 5; c++)
          bus_a.blocks_in[b][r][c] = v;
  endtask

  task automatic start_a();
    start_cyc     = cyc;
    bus_a.control = 1'b1;
  endtask

  initial begin
    bus_a.control = 1'b0;
    bus_b.control = 1'b0;
    fill_a_const('0);
    for (int b = 0; b < 4; b++)
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          bus_b.blocks_in[b][r][c] = 32'd1;

    // reset state
    step(2);
    push(0, 1, 0, 0, 32'd0, "reset_done");
    push(0, 0, 0, 0, 32'd0, "reset_cell00");
    push(0, 0, 7, 7, 32'd0, "reset_cell77");
    push(1, 1, 0, 0, 32'd0, "reset_done_b");
    snap("reset");
    reset = 1'b1;
    step(2);

    // all tiles = 3, control held high
    fill_a_const(32'd3);
    push(0, 1, 0, 0, 32'd1,  "t3_done");
    push(0, 2, 0, 0, 32'd17, "t3_latency");
    push(0, 0, 0, 0, 32'd3,  "t3_cell00");
    push(0, 0, 1, 2, 32'd18, "t3_cell12");
    push(0, 0, 3, 3, 32'd48, "t3_cell33");
    push(0, 0, 3, 4, 32'd48, "t3_cell34");
    push(0, 0, 0, 7, 32'd3,  "t3_cell07");
    push(0, 0, 7, 7, 32'd3,  "t3_cell77");
    start_a();
    wait_drain(40, "t3_run");
    step(5);
    push(0, 1, 0, 0, 32'd1,  "hold_done");
    push(0, 0, 3, 3, 32'd48, "hold_cell33");
    snap("hold");

    // drop control: done clears, plane is retained
    bus_a.control = 1'b0;
    step(2);
    push(0, 1, 0, 0, 32'd0,  "idle_done");
    push(0, 0, 3, 3, 32'd48, "idle_cell33");
    snap("idle");

    // tile b filled with b+1
    for (int b = 0; b < 16; b++)
      for (int r = 0; r < 5; r++)
        for (int c = 0; c < 5; c++)
          bus_a.blocks_in[b][r][c] = data_t'(b + 1);
    push(0, 1, 0, 0, 32'd1,   "ramp_done");
    push(0, 0, 0, 0, 32'd1,   "ramp_cell00");
    push(0, 0, 7, 7, 32'd16,  "ramp_cell77");
    push(0, 0, 0, 7, 32'd4,   "ramp_cell07");
    push(0, 0, 7, 0, 32'd13,  "ramp_cell70");
    push(0, 0, 4, 4, 32'd136, "ramp_cell44");
    start_a();
    wait_drain(40, "ramp_run");
    bus_a.control = 1'b0;
    step(2);

    // reset in the middle of accumulation, after 5 tiles
    fill_a_const(32'd7);
    start_a();
    step(6);
    reset         = 1'b0;
    bus_a.control = 1'b0;
    push(0, 1, 0, 0, 32'd0, "abort_done");
    push(0, 0, 0, 0, 32'd0, "abort_cell00");
    push(0, 0, 4, 4, 32'd0, "abort_cell44");
    snap("abort");
    step(2);
    reset = 1'b1;
    step(2);
    push(0, 1, 0, 0, 32'd1,   "rerun_done");
    push(0, 2, 0, 0, 32'd17,  "rerun_latency");
    push(0, 0, 0, 0, 32'd7,   "rerun_cell00");
    push(0, 0, 3, 3, 32'd112, "rerun_cell33");
    start_a();
    wait_drain(40, "rerun_run");
    bus_a.control = 1'b0;
    step(2);

    // all tiles = 1: full plane must be w(r)*w(c), no carry-over
    fill_a_const(32'd1);
    push(0, 1, 0, 0, 32'd1,  "ones_done");
    push(0, 2, 0, 0, 32'd17, "ones_latency");
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        push(0, 0, r, c, data_t'(w_tab[r] * w_tab[c]), "ones_plane");
    start_a();
    wait_drain(40, "ones_run");
    bus_a.control = 1'b0;
    step(2);

    // control falling during accumulation is ignored
    fill_a_const(32'd2);
    push(0, 1, 0, 0, 32'd1,  "drop_done");
    push(0, 2, 0, 0, 32'd17, "drop_latency");
    push(0, 0, 0, 0, 32'd2,  "drop_cell00");
    push(0, 0, 3, 3, 32'd32, "drop_cell33");
    start_a();
    step(3);
    bus_a.control = 1'b0;
    wait_drain(40, "drop_run");
    step(2);
    push(0, 1, 0, 0, 32'd0, "drop_idle_done");
    snap("drop_idle");

    // overflow behaviour
    fill_a_const(32'h8000_0000);
    push(0, 1, 0, 0, 32'd1, "ovf_done");
    push(0, 0, 0, 0, 32'h8000_0000, "ovf_cell00");
`ifdef OVA_SATURATE_EN
    push(0, 0, 0, 1, 32'hFFFF_FFFF, "ovf_cell01");
    push(0, 0, 4, 4, 32'hFFFF_FFFF, "ovf_cell44");
`else
    push(0, 0, 0, 1, 32'h0000_0000, "ovf_cell01");
    push(0, 0, 4, 4, 32'h0000_0000, "ovf_cell44");
`endif
    start_a();
    wait_drain(40, "ovf_run");
    bus_a.control = 1'b0;
    step(2);

    // 2x2 grid of 3x3 tiles, overlap 1 -> 5x5 plane
    push(1, 1, 0, 0, 32'd1, "small_done");
    push(1, 2, 0, 0, 32'd5, "small_latency");
    push(1, 0, 0, 0, 32'd1, "small_cell00");
    push(1, 0, 0, 4, 32'd1, "small_cell04");
    push(1, 0, 4, 4, 32'd1, "small_cell44");
    push(1, 0, 1, 1, 32'd1, "small_cell11");
    push(1, 0, 2, 0, 32'd2, "small_cell20");
    push(1, 0, 0, 2, 32'd2, "small_cell02");
    push(1, 0, 2, 2, 32'd4, "small_cell22");
    start_cyc     = cyc;
    bus_b.control = 1'b1;
    wait_drain(20, "small_run");
    bus_b.control = 1'b0;
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/overlap_add.md
Name: overlap_add

Overview:
- Overlap-add (OVA) reassembly stage for the CNN datapath.
- Takes num_block_root² square tiles of size×size 32-bit values and sums them into one output plane.
- Tiles are laid on a grid with stride (size−overlap).
- Accumulates one tile per clock after a start request and holds the assembled plane until the next run.

Parameters:
- num_block_root, 4, tiles per grid row and per grid column; tile count N = num_block_root².
- size, 5, tile edge length in elements.
- overlap, size−1, overlapping elements between neighbouring tiles; legal range 0..size−1, so stride = size−overlap ≥ 1.
- outputsize (localparam), num_block_root·size − (num_block_root−1)·overlap, output plane edge; 8 with the defaults.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous active-low reset (0 = reset asserted).
- control  in  1  level start request.
- blocks_in  in  32 × [N][size][size]  unpacked tile array, tile b, row, col; unsigned.
- overlap_data  out  32 × [outputsize][outputsize]  registered accumulated plane; unsigned.
- done  out  1  high while a finished result is held.

Behaviour:
- Tile placement: tile b sits at grid row gr = b / num_block_root and grid col gc = b % num_block_root. Its element [r][c] adds into overlap_data[gr·stride + r][gc·stride + c].
- Reset (reset = 0, async): state ← IDLE, tile counter k ← 0, every overlap_data element ← 0, done ← 0.
- FSM states:
  - IDLE: when control = 1 at a clock edge, clear all overlap_data to 0, set k = 0, go to ACCUM.
  - ACCUM: each edge, add tile k into its window of overlap_data and increment k. After the edge that adds tile N−1, go to DONE and set done = 1.
  - DONE: overlap_data and done hold. When control = 0, go to IDLE and drop done; overlap_data keeps its values until the next start clears it.
- Latency: start edge plus N accumulate edges. With the defaults, the result is valid 17 edges after control is first sampled high.
- control held high continuously produces exactly one run; a new run needs control low (DONE→IDLE) and then high again.
- control falling during ACCUM is ignored; the run completes.
- blocks_in is sampled per tile on its accumulate edge and must be stable from the start edge until done.
- Arithmetic: unsigned 32-bit add, modulo 2³² wrap (default build).
- Elements outside every tile window are impossible by construction; every output cell is covered by at least one tile.
- Reset asserted mid-run aborts immediately to the reset values; no partial result is retained.

Optional Feature:
- Macro: OVA_SATURATE_EN.
- Defined: each accumulation saturates at 32'hFFFF_FFFF instead of wrapping.
- Undefined: modulo 2³² wrap-around.
- No other behavioural difference.

Decomposition:
- Shared package ova_pkg:
  - DATA_W = 32.
  - data_t typedef (logic [DATA_W−1:0]).
  - State enum {IDLE, ACCUM, DONE}.
  - add function implementing wrap vs saturate (selected by OVA_SATURATE_EN).
- One natural sub-module, ova_tile_window: combinational. Given k, it produces the gr/gc offsets and a per-output-cell add value (tile element or 0), which the top-level registers accumulate.

Test Plan (default parameters, outputsize = 8):
- All tiles filled with 3, reset released, control raised and held → after 17 edges done = 1. overlap_data[r][c] = 3·w(r)·w(c), where w = 1,2,3,4,4,3,2,1. Spot values: [0][0]=3, [1][2]=18, [3][3]=48, [3][4]=48, [0][7]=3, [7][7]=3.
- Tile b filled with value b+1, others as given → [0][0]=1, [7][7]=16, [0][7]=4; [4][4] = sum of (b+1) over all 16 tiles = 136.
- Reset pulsed low in the middle of ACCUM (after 5 tiles) → all outputs 0 and done = 0 immediately (asynchronous). A later start gives the full correct result.
- control dropped to 0 during DONE, then raised again with all tiles = 1 → plane recleared, result = w(r)·w(c) (e.g. [3][3]=16), with no carry-over from the previous run.
- All tiles 32'h8000_0000:
  - Wrap build: [0][0]=32'h8000_0000, [0][1]=0.
  - OVA_SATURATE_EN build: [0][1]=32'hFFFF_FFFF.
- Parameter override num_block_root=2, size=3, overlap=1, all tiles = 1 → outputsize 5; middle row and middle column = 2, centre [2][2]=4, corners = 1.
